rf_dump: RTL and testbench
==========================

# rf_dump

Debug read-out engine for the MCPU register file. On a start pulse it walks register addresses 0..NREG-1 through one register-file read port, snapshots each value, and emits a 5-byte frame per register on a valid/ready byte stream. The stream feeds the board's debug byte channel (UART TX or similar). It replaces ad-hoc simulation prints with a synthesizable dump path.

## Interface
Parameters:
- NREG, 32, number of registers scanned (addresses 0..NREG-1)
- AW, 5, register address width; NREG ≤ 2**AW
- DW, 32, register data width; fixed at 32 (4 data bytes per frame)

Ports:
- clk  in  1  system clock; one clock domain, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request to begin a dump
- ra  out  AW  read address to the register-file read port (registered)
- rd  in  DW  combinational read data from the register file for address ra
- busy  out  1  high from the cycle after start is accepted until DONE exits
- done  out  1  one-cycle pulse after the last frame's final byte is accepted
- tx_data  out  8  stream byte
- tx_valid  out  1  stream byte valid
- tx_ready  in  1  sink accepts the byte when tx_valid && tx_ready at a rising edge

## Operation
- Frame per register: byte0 = {zero-pad, ra}; bytes 1..4 = snapshot[31:24], [23:16], [15:8], [7:0] (MSB first). 5*NREG bytes per dump (160 at default).
- States: IDLE, LATCH, SEND, NEXT, DONE.
- IDLE: busy=0, tx_valid=0. If start=1: ra←0 → LATCH.
- LATCH: snapshot←rd (ra has been stable for ≥1 cycle); byte index←0 → SEND.
- SEND: tx_valid=1, tx_data=frame byte[index]. On handshake: if index==4 → NEXT, else index+1. Without handshake, tx_data and tx_valid hold unchanged.
- NEXT: if ra==NREG-1 → DONE, else ra←ra+1 → LATCH.
- DONE: done=1 for exactly one cycle → IDLE.
- start is ignored outside IDLE, with no queuing.
- Snapshot isolation: register-file writes during SEND do not change the frame in flight. A write to a register not yet latched appears in that register's frame.
- tx_data is 0 in all states other than SEND.

## Timing
- Reset (async assert, any state): state=IDLE, ra=0, index=0, snapshot=0, busy=0, done=0, tx_valid=0, tx_data=0. Outputs drop immediately on assertion, not at the next edge. A frame cut off by reset is not resumed.
- Edge E0 samples start → LATCH in cycle 1 and first tx_valid in cycle 2.
- Register k with tx_ready held high: LATCH at cycle 1+7k, SEND at cycles 2+7k..6+7k, NEXT at 7+7k.
- Default NREG=32 with tx_ready high: done pulses in cycle 225. busy is high in cycles 1..225.
- Each cycle with tx_ready low during SEND adds exactly one cycle.
- Back-to-back: a start asserted in the cycle right after DONE (state IDLE) is accepted.

## Structure
- Shared package (rf_dump_pkg): state enum {IDLE, LATCH, SEND, NEXT, DONE} and FRAME_BYTES=5. Other debug blocks reuse both.
- No sub-module. Byte selection is a 5-way mux inside rf_dump. The bench provides a behavioural 32×32 register-file model with combinational read.

## Test plan
- Preload reg[i]=32'hA5000000|i, tx_ready=1, pulse start: 160 bytes in order; frame 3 = 03 A5 00 00 03; done in cycle 225; busy high in cycles 1..225.
- Same as above, with tx_ready toggling on a pseudo-random pattern: identical byte sequence; tx_data/tx_valid never change while tx_valid && !tx_ready.
- Write reg[5]=32'hDEADBEEF during frame 5's SEND: frame 5 carries the old value. Write reg[20]=32'h12345678 mid-dump: frame 20 = 14 12 34 56 78.
- Assert start repeatedly while busy: a single dump of 160 bytes and one done pulse. Start in the cycle after done: a second full dump begins.
- Assert rst_n low during frame 10 byte 2 between edges: tx_valid, busy = 0 immediately; ra=0. The next start yields a complete dump beginning with frame 0.
- NREG=4 build: 20 bytes, done in cycle 29, and ra never exceeds 3.

Source files
------------

// File: rtl/rf_dump_pkg.sv
// rtl/rf_dump_pkg.sv - shared state encoding and frame geometry for debug dump blocks
package rf_dump_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    SEND,
    NEXT,
    DONE
  } dump_state_e;

  localparam int FRAME_BYTES = 5;

endpackage

// File: rtl/rf_dump_if.sv
// rtl/rf_dump_if.sv - valid/ready byte stream carrying dump frames to the debug channel
interface rf_dump_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/rf_dump.sv
// rtl/rf_dump.sv - walks the register file and emits {addr, data[31:0]} frames MSB first
module rf_dump
  import rf_dump_pkg::*;
#(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic [AW-1:0] ra,
  input  logic [DW-1:0] rd,
  output logic          busy,
  output logic          done,
  rf_dump_if.master     tx
);

  localparam logic [AW-1:0] LAST_RA  = AW'(NREG - 1);
  localparam logic [2:0]    LAST_IDX = 3'(FRAME_BYTES - 1);

  dump_state_e   state_q, state_d;
  logic [AW-1:0] ra_q, ra_d;
  logic [2:0]    idx_q, idx_d;
  logic [DW-1:0] snap_q, snap_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          tx_valid_q, tx_valid_d;
  logic [7:0]    tx_data_q, tx_data_d;

  function automatic logic [7:0] frame_byte(input logic [AW-1:0] addr,
                                            input logic [DW-1:0] word,
                                            input logic [2:0]    idx);
    case (idx)
      3'd0:    frame_byte = 8'(addr);
      3'd1:    frame_byte = word[31:24];
      3'd2:    frame_byte = word[23:16];
      3'd3:    frame_byte = word[15:8];
      3'd4:    frame_byte = word[7:0];
      default: frame_byte = 8'h00;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    idx_d   = idx_q;
    snap_d  = snap_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          ra_d    = '0;
          state_d = LATCH;
        end
      end
      LATCH: begin
        snap_d  = rd;
        idx_d   = '0;
        state_d = SEND;
      end
      SEND: begin
        if (tx.tx_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = NEXT;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      NEXT: begin
        if (ra_q == LAST_RA) begin
          state_d = DONE;
        end else begin
          ra_d    = ra_q + AW'(1);
          state_d = LATCH;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it cycle-for-cycle.
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
    tx_valid_d = (state_d == SEND);
    tx_data_d  = tx_valid_d ? frame_byte(ra_d, snap_d, idx_d) : 8'h00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ra_q       <= '0;
      idx_q      <= '0;
      snap_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      ra_q       <= ra_d;
      idx_q      <= idx_d;
      snap_q     <= snap_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign ra          = ra_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign tx.tx_data  = tx_data_q;
  assign tx.tx_valid = tx_valid_q;

endmodule

// File: tb/tb_rf_dump.sv
// tb/tb_rf_dump.sv - randomized bench for rf_dump against a frame-level reference model
module tb_rf_dump;
  import rf_dump_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_a, start_b;
  logic [4:0]  ra_a, ra_b;
  logic [31:0] rd_a, rd_b;
  logic        busy_a, done_a, busy_b, done_b;

  logic [31:0] regs [0:31];
  assign rd_a = regs[ra_a];
  assign rd_b = regs[ra_b];

  rf_dump_if ifa ();
  rf_dump_if ifb ();

  rf_dump #(.NREG(32), .AW(5), .DW(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .ra(ra_a), .rd(rd_a),
    .busy(busy_a), .done(done_a), .tx(ifa)
  );

  rf_dump #(.NREG(4), .AW(5), .DW(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .ra(ra_b), .rd(rd_b),
    .busy(busy_b), .done(done_b), .tx(ifb)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference: the word each frame must carry, and the bytes actually accepted.
  logic [31:0] exp_word [0:31];
  logic [7:0]  got [$];
  int          done_cycle, busy_bad, hold_bad, stalls;
  bit          timeout;

  function automatic logic [7:0] exp_byte(input int n);
    int          f = n / FRAME_BYTES;
    int          b = n % FRAME_BYTES;
    logic [31:0] w = exp_word[f];
    if (b == 0) return 8'(f);
    return w[8*(4-b) +: 8];
  endfunction

  function automatic int first_bad(input int nbytes);
    for (int i = 0; i < nbytes; i++) begin
      if (i >= got.size()) return i;
      if (got[i] !== exp_byte(i)) return i;
    end
    if (got.size() != nbytes) return nbytes;
    return -1;
  endfunction

  function automatic logic [7:0] got_at(input int i);
    if (i >= 0 && i < got.size()) return got[i];
    return 8'hxx;
  endfunction

  task automatic load_pattern();
    for (int i = 0; i < 32; i++) regs[i] = 32'hA500_0000 | 32'(i);
    for (int i = 0; i < 32; i++) exp_word[i] = regs[i];
  endtask

  task automatic load_random();
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    for (int i = 0; i < 32; i++) exp_word[i] = regs[i];
  endtask

  // A write only reaches the stream if its register has not been latched yet.
  task automatic write_reg(input int k, input logic [31:0] v);
    regs[k] = v;
    if (k > got.size() / FRAME_BYTES) exp_word[k] = v;
  endtask

  // Called at a negedge while dut_a is idle; start is sampled at the next edge (cycle 0 -> 1).
  task automatic collect(input int ready_pct, input bit do_writes, input bit spam, input int abort_at);
    int         c = 0;
    bit         prev_stall = 1'b0;
    logic       prev_valid = 1'b0;
    logic [7:0] prev_data = 8'h00;
    bit         w5 = 1'b0, w20 = 1'b0;
    got.delete();
    done_cycle = -1; busy_bad = 0; hold_bad = 0; stalls = 0; timeout = 1'b0;
    start_a = 1'b1;
    forever begin
      if (c > 0) begin
        if (prev_stall && (ifa.tx_valid !== prev_valid || ifa.tx_data !== prev_data)) hold_bad++;
        if (busy_a !== 1'b1) busy_bad++;
        if (done_a === 1'b1) begin
          done_cycle = c;
          start_a = 1'b0;
          return;
        end
      end
      if (abort_at >= 0 && got.size() == abort_at && ifa.tx_valid === 1'b1) begin
        start_a = 1'b0;
        return;
      end
      if (do_writes && !w5 && got.size() == 26) begin
        write_reg(5, 32'hDEAD_BEEF); w5 = 1'b1;
      end
      if (do_writes && !w20 && got.size() == 50) begin
        write_reg(20, 32'h1234_5678); w20 = 1'b1;
      end
      ifa.tx_ready = ($urandom_range(99) < 32'(ready_pct));
      if (ifa.tx_valid === 1'b1 && ifa.tx_ready) got.push_back(ifa.tx_data);
      prev_stall = (ifa.tx_valid === 1'b1) && !ifa.tx_ready;
      if (prev_stall) stalls++;
      prev_valid = ifa.tx_valid;
      prev_data  = ifa.tx_data;
      if (c > 0) start_a = (spam && c < 200) ? 1'($urandom_range(1)) : 1'b0;
      if (c >= 3000) begin
        timeout = 1'b1;
        start_a = 1'b0;
        return;
      end
      @(negedge clk);
      c++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; start_a = 1'b0; start_b = 1'b0;
    ifa.tx_ready = 1'b0; ifb.tx_ready = 1'b1;
    load_pattern();
    #3 rst_n = 1'b0;
    #1;
    n_vec++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    n_vec++; if (done_a !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done_a); end
    n_vec++; if (ifa.tx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", ifa.tx_valid); end
    n_vec++; if (ifa.tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", ifa.tx_data); end
    n_vec++; if (ra_a !== 5'd0) begin n_bad++; $display("FAIL reset_ra: got %0d want 0", ra_a); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if (busy_a !== 1'b0 || ifa.tx_valid !== 1'b0) begin
      n_bad++; $display("FAIL idle_quiet: busy %b valid %b want 0 0", busy_a, ifa.tx_valid);
    end
  endtask

  task automatic test_basic();
    int fb;
    load_pattern();
    collect(100, 1'b0, 1'b0, -1);
    n_vec++; if (timeout) begin n_bad++; $display("FAIL basic_timeout: no done within budget"); end
    fb = first_bad(160);
    n_vec++; if (fb != -1) begin
      n_bad++; $display("FAIL basic_stream: byte %0d got %h want %h (%0d bytes)", fb, got_at(fb), exp_byte(fb), got.size());
    end
    n_vec++; if ({got_at(15), got_at(16), got_at(17), got_at(18), got_at(19)} !== 40'h03_A5_00_00_03) begin
      n_bad++; $display("FAIL basic_frame3: got %h%h%h%h%h want 03a5000003",
                        got_at(15), got_at(16), got_at(17), got_at(18), got_at(19));
    end
    n_vec++; if (done_cycle != 225) begin n_bad++; $display("FAIL basic_done_cycle: got %0d want 225", done_cycle); end
    n_vec++; if (busy_bad != 0) begin n_bad++; $display("FAIL basic_busy: %0d low cycles want 0", busy_bad); end
    @(negedge clk);
    n_vec++; if (done_a !== 1'b0 || busy_a !== 1'b0) begin
      n_bad++; $display("FAIL basic_after_done: done %b busy %b want 0 0", done_a, busy_a);
    end
  endtask

  task automatic test_backpressure();
    int fb;
    load_pattern();
    collect(55, 1'b0, 1'b0, -1);
    fb = first_bad(160);
    n_vec++; if (fb != -1) begin
      n_bad++; $display("FAIL bp_stream: byte %0d got %h want %h (%0d bytes)", fb, got_at(fb), exp_byte(fb), got.size());
    end
    n_vec++; if (hold_bad != 0) begin n_bad++; $display("FAIL bp_hold: %0d changes while stalled want 0", hold_bad); end
    n_vec++; if (done_cycle != 225 + stalls) begin
      n_bad++; $display("FAIL bp_done_cycle: got %0d want %0d", done_cycle, 225 + stalls);
    end
    n_vec++; if (busy_bad != 0) begin n_bad++; $display("FAIL bp_busy: %0d low cycles want 0", busy_bad); end
    @(negedge clk);
  endtask

  task automatic test_snapshot();
    int          fb;
    logic [31:0] old5;
    load_random();
    old5 = regs[5];
    collect(70, 1'b1, 1'b0, -1);
    fb = first_bad(160);
    n_vec++; if (fb != -1) begin
      n_bad++; $display("FAIL snap_stream: byte %0d got %h want %h (%0d bytes)", fb, got_at(fb), exp_byte(fb), got.size());
    end
    n_vec++; if ({got_at(26), got_at(27), got_at(28), got_at(29)} !== old5) begin
      n_bad++; $display("FAIL snap_frame5: got %h%h%h%h want %h", got_at(26), got_at(27), got_at(28), got_at(29), old5);
    end
    n_vec++; if ({got_at(100), got_at(101), got_at(102), got_at(103), got_at(104)} !== 40'h14_12_34_56_78) begin
      n_bad++; $display("FAIL snap_frame20: got %h%h%h%h%h want 1412345678",
                        got_at(100), got_at(101), got_at(102), got_at(103), got_at(104));
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int fb;
    load_random();
    collect(100, 1'b0, 1'b1, -1);
    fb = first_bad(160);
    n_vec++; if (fb != -1) begin
      n_bad++; $display("FAIL spam_stream: byte %0d got %h want %h (%0d bytes)", fb, got_at(fb), exp_byte(fb), got.size());
    end
    n_vec++; if (done_cycle != 225) begin n_bad++; $display("FAIL spam_done_cycle: got %0d want 225", done_cycle); end
    @(negedge clk);
    n_vec++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin
      n_bad++; $display("FAIL spam_idle: busy %b done %b want 0 0", busy_a, done_a);
    end
    collect(100, 1'b0, 1'b0, -1);
    fb = first_bad(160);
    n_vec++; if (fb != -1) begin
      n_bad++; $display("FAIL b2b_stream: byte %0d got %h want %h (%0d bytes)", fb, got_at(fb), exp_byte(fb), got.size());
    end
    n_vec++; if (done_cycle != 225) begin n_bad++; $display("FAIL b2b_done_cycle: got %0d want 225", done_cycle); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    int fb;
    load_random();
    collect(100, 1'b0, 1'b0, 52);
    n_vec++; if (ifa.tx_data !== exp_word[10][23:16]) begin
      n_bad++; $display("FAIL abort_byte: got %h want %h", ifa.tx_data, exp_word[10][23:16]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (ifa.tx_valid !== 1'b0 || busy_a !== 1'b0) begin
      n_bad++; $display("FAIL abort_async: valid %b busy %b want 0 0", ifa.tx_valid, busy_a);
    end
    n_vec++; if (ra_a !== 5'd0 || ifa.tx_data !== 8'h00) begin
      n_bad++; $display("FAIL abort_state: ra %0d data %h want 0 00", ra_a, ifa.tx_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    collect(100, 1'b0, 1'b0, -1);
    fb = first_bad(160);
    n_vec++; if (fb != -1) begin
      n_bad++; $display("FAIL restart_stream: byte %0d got %h want %h (%0d bytes)", fb, got_at(fb), exp_byte(fb), got.size());
    end
    n_vec++; if (done_cycle != 225) begin n_bad++; $display("FAIL restart_done_cycle: got %0d want 225", done_cycle); end
    @(negedge clk);
  endtask

  task automatic test_nreg4();
    int fb;
    int c = 0;
    int dcyc = -1;
    int max_ra = 0;
    load_random();
    got.delete();
    ifb.tx_ready = 1'b1;
    start_b = 1'b1;
    while (c < 200 && dcyc < 0) begin
      @(negedge clk);
      c++;
      start_b = 1'b0;
      if (int'(ra_b) > max_ra) max_ra = int'(ra_b);
      if (done_b === 1'b1) dcyc = c;
      if (ifb.tx_valid === 1'b1) got.push_back(ifb.tx_data);
    end
    fb = first_bad(20);
    n_vec++; if (fb != -1) begin
      n_bad++; $display("FAIL n4_stream: byte %0d got %h want %h (%0d bytes)", fb, got_at(fb), exp_byte(fb), got.size());
    end
    n_vec++; if (dcyc != 29) begin n_bad++; $display("FAIL n4_done_cycle: got %0d want 29", dcyc); end
    n_vec++; if (max_ra != 3) begin n_bad++; $display("FAIL n4_max_ra: got %0d want 3", max_ra); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_snapshot();
    test_back_to_back();
    test_reset_mid_frame();
    test_nreg4();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
